// File: rtl/vertex_frame_controller.sv
// ============================================================================
// Module      : vertex_frame_controller
// Description : Arms on a start request, scans one video frame, collects the
//               vertex hits reported by an external detector into a small
//               buffer, then streams them out over a valid/ready interface.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vertex_frame_controller #(
  parameter int MAX_VERTICES   = 16,
  parameter int DETECT_LATENCY = 4,
  parameter int H_ACTIVE       = 1280,
  parameter int V_ACTIVE       = 720
) (
  input  logic                              clk_in,
  input  logic                              rst_n_in,
  input  logic                              start_in,
  input  logic                              data_valid_in,
  input  logic [10:0]                       hcount_in,
  input  logic [9:0]                        vcount_in,
  output logic                              det_enable_out,
  input  logic                              det_valid_in,
  input  logic [10:0]                       det_hcount_in,
  input  logic [9:0]                        det_vcount_in,
  input  logic                              det_is_vertex_in,
  output logic                              vtx_valid_out,
  input  logic                              vtx_ready_in,
  output logic [10:0]                       vtx_hcount_out,
  output logic [9:0]                        vtx_vcount_out,
  output logic                              vtx_last_out,
  output logic [$clog2(MAX_VERTICES+1)-1:0] vertex_count_out,
  output logic                              overflow_out,
  output logic                              busy_out,
  output logic                              done_out
);

  localparam int CW = $clog2(MAX_VERTICES + 1);
  localparam int AW = (MAX_VERTICES > 1) ? $clog2(MAX_VERTICES) : 1;
  localparam int DW = $clog2(DETECT_LATENCY + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ARMED  = 3'd1;
  localparam logic [2:0] S_SCAN   = 3'd2;
  localparam logic [2:0] S_DRAIN  = 3'd3;
  localparam logic [2:0] S_REPORT = 3'd4;

  logic [2:0]    r_state;
  logic [CW-1:0] r_count;
  logic          r_ovf;
  logic [AW-1:0] r_rd_ptr;
  logic [DW-1:0] r_drain;
  logic          r_done;
  logic [20:0]   r_buf [MAX_VERTICES];

  logic          w_frame_start;
  logic          w_frame_end;
  logic          w_capture;
  logic          w_accept;
  logic [CW-1:0] w_count_nxt;
  logic          w_report;
  logic          w_last;
  logic          w_transfer;
  logic [20:0]   w_rd_word;

  assign w_frame_start = data_valid_in && (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign w_frame_end   = data_valid_in && (hcount_in == 11'(H_ACTIVE - 1))
                                       && (vcount_in == 10'(V_ACTIVE - 1));

  // Detector results only matter while the frame (and its pipeline tail) is live
  assign w_capture   = det_valid_in && det_is_vertex_in &&
                       ((r_state == S_SCAN) || (r_state == S_DRAIN));
  assign w_accept    = w_capture && (r_count < CW'(MAX_VERTICES));
  assign w_count_nxt = w_accept ? (r_count + CW'(1)) : r_count;

  assign w_report   = (r_state == S_REPORT);
  assign w_last     = (CW'(r_rd_ptr) == (r_count - CW'(1)));
  assign w_transfer = w_report && vtx_ready_in;
  assign w_rd_word  = r_buf[r_rd_ptr];

  // Outputs are forced quiet while reset is asserted, even before the edge lands
  assign det_enable_out   = rst_n_in && data_valid_in &&
                            ((r_state == S_SCAN) || ((r_state == S_ARMED) && w_frame_start));
  assign vtx_valid_out    = rst_n_in && w_report;
  assign vtx_last_out     = rst_n_in && w_report && w_last;
  assign vtx_hcount_out   = w_rd_word[20:10];
  assign vtx_vcount_out   = w_rd_word[9:0];
  assign vertex_count_out = r_count;
  assign overflow_out     = r_ovf;
  assign busy_out         = rst_n_in && (r_state != S_IDLE);
  assign done_out         = rst_n_in && r_done;

  // Vertex storage; contents are qualified by r_count so no reset is needed
  always_ff @(posedge clk_in) begin
    if (w_accept) begin
      r_buf[r_count[AW-1:0]] <= {det_hcount_in, det_vcount_in};
    end
  end

  // Capture FSM, vertex counter, overflow flag, read pointer and done pulse
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      r_state  <= S_IDLE;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_rd_ptr <= '0;
      r_drain  <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (start_in) begin
            r_state  <= S_ARMED;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_rd_ptr <= '0;
          end
        end
        S_ARMED: begin
          if (w_frame_start) begin
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (w_frame_end) begin
            r_state <= S_DRAIN;
            r_drain <= DW'(DETECT_LATENCY);
          end
        end
        S_DRAIN: begin
          r_drain <= r_drain - DW'(1);
          if (r_drain == DW'(1)) begin
            // Include a vertex landing on this very edge when deciding
            if (w_count_nxt != '0) begin
              r_state <= S_REPORT;
            end else begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        S_REPORT: begin
          if (w_transfer) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
            if (w_last) begin
              r_state <= S_IDLE;
              r_done  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_capture) begin
        if (w_accept) begin
          r_count <= w_count_nxt;
        end else begin
          r_ovf <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire
